// File: rtl/mat_stream_host.sv
// Streams operand matrices A then B to the accelerator, pulses start, then captures the result stream.
// First operand beat 2 cycles after go, then 1 beat/cycle; a 2-deep prefetch holds the beat while tready is low.
module mat_stream_host #(
    parameter int DIM_LOG    = 2,
    parameter int DIM        = 2**DIM_LOG,
    parameter int SIZE       = DIM*DIM,
    parameter int SIZE_LOG   = 2*DIM_LOG,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      s00_axi_aclk,
    input  logic                      s00_axi_areset,
    input  logic                      cmd_go,
    output logic                      cmd_ready,
    output logic                      done,
    output logic                      err_tlast,
    input  logic                      wr_en,
    input  logic                      wr_sel,
    input  logic [SIZE_LOG-1:0]       wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [SIZE_LOG-1:0]       rd_addr,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      m00_axis_tvalid,
    output logic [DATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                      m00_axis_tlast,
    input  logic                      m00_axis_tready,
    input  logic                      s00_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic                      s00_axis_tlast,
    output logic                      s00_axis_tready,
    output logic                      sel,
    output logic                      start
);

    typedef enum logic [2:0] {S_IDLE, S_SEND_A, S_SEND_B, S_START, S_RECV} state_t;

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_mem_a [SIZE];
    logic [DATA_WIDTH-1:0]   r_mem_b [SIZE];
    logic [DATA_WIDTH-1:0]   r_mem_r [SIZE];
    logic [SIZE_LOG:0]       r_fetch_cnt;
    logic                    r_fetch_done;
    logic                    r_pf_vld;
    logic                    r_pf_last;
    logic [DATA_WIDTH-1:0]   r_pf_dat;
    logic                    r_m_vld;
    logic                    r_m_last;
    logic [DATA_WIDTH-1:0]   r_m_dat;
    logic [SIZE_LOG-1:0]     r_recv_addr;
    logic                    r_cmd_rdy;
    logic                    r_done;
    logic                    r_err;
    logic                    r_s_rdy;
    logic                    r_sel;
    logic                    r_start;
    logic [DATA_WIDTH-1:0]   r_rd_data;

    logic                    w_sending;
    logic                    w_m_hs;
    logic                    w_s_hs;
    logic                    w_out_load;
    logic                    w_pf_load;
    logic [SIZE_LOG-1:0]     w_fetch_addr;
    logic [DATA_WIDTH-1:0]   w_fetch_dat;

    // Fetch counter spans both matrices: MSB selects B, low bits are the element address.
    assign w_sending    = (r_state == S_SEND_A) || (r_state == S_SEND_B);
    assign w_m_hs       = r_m_vld && m00_axis_tready;
    assign w_s_hs       = r_s_rdy && s00_axis_tvalid;
    assign w_out_load   = r_pf_vld && (!r_m_vld || m00_axis_tready);
    assign w_pf_load    = w_sending && !r_fetch_done && (!r_pf_vld || w_out_load);
    assign w_fetch_addr = r_fetch_cnt[SIZE_LOG-1:0];
    assign w_fetch_dat  = r_fetch_cnt[SIZE_LOG] ? r_mem_b[w_fetch_addr] : r_mem_a[w_fetch_addr];

    // Buffers are deliberately left out of reset.
    always_ff @(posedge s00_axi_aclk) begin
        if (r_cmd_rdy && wr_en) begin
            if (wr_sel) r_mem_b[wr_addr] <= wr_data;
            else        r_mem_a[wr_addr] <= wr_data;
        end
        if (r_state == S_RECV && w_s_hs) r_mem_r[r_recv_addr] <= s00_axis_tdata;
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_state      <= S_IDLE;
            r_fetch_cnt  <= '0;
            r_fetch_done <= 1'b0;
            r_pf_vld     <= 1'b0;
            r_pf_last    <= 1'b0;
            r_pf_dat     <= '0;
            r_m_vld      <= 1'b0;
            r_m_last     <= 1'b0;
            r_m_dat      <= '0;
            r_recv_addr  <= '0;
            r_cmd_rdy    <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_s_rdy      <= 1'b0;
            r_sel        <= 1'b0;
            r_start      <= 1'b0;
            r_rd_data    <= '0;
        end else begin
            r_rd_data <= r_mem_r[rd_addr];

            if (w_out_load) begin
                r_m_vld  <= 1'b1;
                r_m_dat  <= r_pf_dat;
                r_m_last <= r_pf_last;
            end else if (w_m_hs) begin
                r_m_vld  <= 1'b0;
            end

            if (w_pf_load) begin
                r_pf_vld    <= 1'b1;
                r_pf_dat    <= w_fetch_dat;
                r_pf_last   <= &w_fetch_addr;
                r_fetch_cnt <= r_fetch_cnt + 1'b1;
                if (&r_fetch_cnt) r_fetch_done <= 1'b1;
            end else if (w_out_load) begin
                r_pf_vld    <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (cmd_go) begin
                        r_state      <= S_SEND_A;
                        r_cmd_rdy    <= 1'b0;
                        r_done       <= 1'b0;
                        r_err        <= 1'b0;
                        r_fetch_cnt  <= '0;
                        r_fetch_done <= 1'b0;
                    end
                end
                S_SEND_A: begin
                    if (w_m_hs && r_m_last) begin
                        r_state <= S_SEND_B;
                        r_sel   <= 1'b1;
                    end
                end
                S_SEND_B: begin
                    if (w_m_hs && r_m_last) begin
                        r_state <= S_START;
                        r_start <= 1'b1;
                    end
                end
                S_START: begin
                    r_state     <= S_RECV;
                    r_start     <= 1'b0;
                    r_s_rdy     <= 1'b1;
                    r_recv_addr <= '0;
                end
                S_RECV: begin
                    if (w_s_hs) begin
                        r_recv_addr <= r_recv_addr + 1'b1;
                        // Run ends on tlast or the SIZE-th beat; flag whenever the two disagree.
                        if (s00_axis_tlast || (&r_recv_addr)) begin
                            r_state   <= S_IDLE;
                            r_s_rdy   <= 1'b0;
                            r_sel     <= 1'b0;
                            r_done    <= 1'b1;
                            r_cmd_rdy <= 1'b1;
                            r_err     <= s00_axis_tlast ^ (&r_recv_addr);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready       = r_cmd_rdy;
    assign done            = r_done;
    assign err_tlast       = r_err;
    assign rd_data         = r_rd_data;
    assign m00_axis_tvalid = r_m_vld;
    assign m00_axis_tdata  = r_m_dat;
    assign m00_axis_tstrb  = {(DATA_WIDTH/8){1'b1}};
    assign m00_axis_tlast  = r_m_last;
    assign s00_axis_tready = r_s_rdy;
    assign sel             = r_sel;
    assign start           = r_start;

endmodule

// File: tb/tb_mat_stream_host.sv
// Bench for mat_stream_host: randomized operand/result traffic checked against a queue-free array model.
module tb_mat_stream_host;

    localparam int SIZE = 16;
    localparam int DW   = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_go, cmd_ready, done, err_tlast;
    logic            wr_en, wr_sel;
    logic [3:0]      wr_addr, rd_addr;
    logic [DW-1:0]   wr_data, rd_data;
    logic            m_tvalid, m_tlast, m_tready;
    logic [DW-1:0]   m_tdata;
    logic [3:0]      m_tstrb;
    logic            s_tvalid, s_tlast, s_tready;
    logic [DW-1:0]   s_tdata;
    logic            sel, start;

    always #5 clk = ~clk;

    mat_stream_host #(.DIM_LOG(2), .DATA_WIDTH(DW)) dut (
        .s00_axi_aclk(clk), .s00_axi_areset(rst),
        .cmd_go(cmd_go), .cmd_ready(cmd_ready), .done(done), .err_tlast(err_tlast),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .m00_axis_tvalid(m_tvalid), .m00_axis_tdata(m_tdata), .m00_axis_tstrb(m_tstrb),
        .m00_axis_tlast(m_tlast), .m00_axis_tready(m_tready),
        .s00_axis_tvalid(s_tvalid), .s00_axis_tdata(s_tdata), .s00_axis_tlast(s_tlast),
        .s00_axis_tready(s_tready), .sel(sel), .start(start)
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] ma [SIZE];
    logic [DW-1:0] mb [SIZE];
    logic [DW-1:0] mr [SIZE];
    bit            mr_known [SIZE];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready got %b exp 1", cmd_ready); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b exp 0", done); end
        n_checks++; if (err_tlast !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b exp 0", err_tlast); end
        n_checks++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin n_fail++; $display("FAIL rst_m_axis got vld=%b last=%b exp 0/0", m_tvalid, m_tlast); end
        n_checks++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL rst_s_tready got %b exp 0", s_tready); end
        n_checks++; if (sel !== 1'b0 || start !== 1'b0) begin n_fail++; $display("FAIL rst_sel_start got sel=%b start=%b exp 0/0", sel, start); end
        n_checks++; if (rd_data !== '0) begin n_fail++; $display("FAIL rst_rd_data got %h exp 0", rd_data); end
        n_checks++; if (m_tstrb !== 4'hf) begin n_fail++; $display("FAIL tstrb got %h exp f", m_tstrb); end
        rst = 1'b0;
        tick();
    endtask

    // pattern=1 loads A[i]=i, B[i]=16+i; otherwise random values.
    task automatic load_operands(input bit pattern);
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < SIZE; i++) begin
                wr_en   = 1'b1;
                wr_sel  = m[0];
                wr_addr = i[3:0];
                wr_data = pattern ? DW'(m * SIZE + i) : $urandom;
                if (m == 0) ma[i] = wr_data; else mb[i] = wr_data;
                tick();
            end
        end
        wr_en = 1'b0;
    endtask

    // mode: 0 tready=1, 1 alternating, 2 random. abort_at>=0 resets just before that beat.
    task automatic send_operands(input int mode, input int abort_at, input bit noise, input bit same_wr);
        int            k, beat, gaps;
        bit            first_seen, prev_stall, hs;
        logic [DW-1:0] prev_dat, exp_dat;
        logic          prev_last, exp_last, exp_sel;
        cmd_go = 1'b1;
        if (same_wr) begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = $urandom; ma[0] = wr_data;
        end
        tick();
        cmd_go = 1'b0;
        wr_en  = 1'b0;
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL go_cmd_ready got %b exp 0", cmd_ready); end
        n_checks++; if (done !== 1'b0 || err_tlast !== 1'b0) begin n_fail++; $display("FAIL go_clears_sticky got done=%b err=%b exp 0/0", done, err_tlast); end
        k = 0; beat = 0; gaps = 0; first_seen = 0; prev_stall = 0; prev_dat = '0; prev_last = 1'b0;
        while (beat < 2 * SIZE && k < 500) begin
            if (m_tvalid && !first_seen) begin
                first_seen = 1;
                n_checks++; if (k != 2) begin n_fail++; $display("FAIL first_beat_latency got %0d exp 2", k); end
            end
            if (prev_stall) begin
                n_checks++;
                if (m_tvalid !== 1'b1 || m_tdata !== prev_dat || m_tlast !== prev_last) begin
                    n_fail++; $display("FAIL stall_hold got vld=%b dat=%h last=%b exp 1/%h/%b", m_tvalid, m_tdata, m_tlast, prev_dat, prev_last);
                end
            end
            n_checks++; if (s_tready !== 1'b0 || start !== 1'b0) begin n_fail++; $display("FAIL send_idle_ctl got s_tready=%b start=%b exp 0/0", s_tready, start); end
            if (abort_at >= 0 && beat == abort_at && m_tvalid) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                n_checks++;
                if (m_tvalid !== 1'b0 || sel !== 1'b0 || start !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0 || s_tready !== 1'b0) begin
                    n_fail++; $display("FAIL abort_state got vld=%b sel=%b start=%b rdy=%b done=%b exp 0/0/0/1/0", m_tvalid, sel, start, cmd_ready, done);
                end
                return;
            end
            case (mode)
                0:       m_tready = 1'b1;
                1:       m_tready = (k % 2 == 0);
                default: m_tready = $urandom_range(0, 1) != 0;
            endcase
            hs = m_tvalid && m_tready;
            if (hs) begin
                exp_dat  = (beat < SIZE) ? ma[beat] : mb[beat - SIZE];
                exp_last = (beat == SIZE - 1) || (beat == 2 * SIZE - 1);
                exp_sel  = (beat >= SIZE);
                n_checks++;
                if (m_tdata !== exp_dat || m_tlast !== exp_last || sel !== exp_sel) begin
                    n_fail++; $display("FAIL beat%0d got dat=%h last=%b sel=%b exp %h/%b/%b", beat, m_tdata, m_tlast, sel, exp_dat, exp_last, exp_sel);
                end
                beat++;
                prev_stall = 0;
            end else if (m_tvalid) begin
                prev_stall = 1; prev_dat = m_tdata; prev_last = m_tlast;
            end else begin
                prev_stall = 0;
                if (first_seen) gaps++;
            end
            cmd_go = noise && ($urandom_range(0, 3) == 0);
            wr_en  = noise && ($urandom_range(0, 1) == 0);
            wr_sel = $urandom_range(0, 1) != 0;
            wr_addr = 4'($urandom_range(0, 15));
            wr_data = $urandom;
            tick();
            k++;
        end
        cmd_go = 1'b0; wr_en = 1'b0; m_tready = 1'b0;
        n_checks++; if (beat != 2 * SIZE) begin n_fail++; $display("FAIL send_timeout got %0d beats exp 32", beat); end
        if (mode == 0) begin
            n_checks++; if (gaps != 0) begin n_fail++; $display("FAIL send_bubbles got %0d exp 0", gaps); end
        end
        n_checks++; if (start !== 1'b1 || m_tvalid !== 1'b0 || sel !== 1'b1) begin n_fail++; $display("FAIL start_cycle got start=%b vld=%b sel=%b exp 1/0/1", start, m_tvalid, sel); end
        tick();
        n_checks++; if (start !== 1'b0 || s_tready !== 1'b1 || sel !== 1'b1) begin n_fail++; $display("FAIL recv_entry got start=%b s_tready=%b sel=%b exp 0/1/1", start, s_tready, sel); end
    endtask

    // tlast_idx<0: no tlast. base>=0: beat i carries base+i, else random.
    task automatic feed_results(input int tlast_idx, input int base);
        int            idx, k, n_exp;
        bit            err_exp, rd_pend;
        logic [DW-1:0] rd_exp;
        logic [DW-1:0] dat [SIZE];
        for (int i = 0; i < SIZE; i++) dat[i] = (base >= 0) ? DW'(base + i) : $urandom;
        n_exp   = (tlast_idx >= 0 && tlast_idx < SIZE) ? tlast_idx + 1 : SIZE;
        err_exp = (tlast_idx != SIZE - 1);
        idx = 0; k = 0; rd_pend = 0; rd_exp = '0;
        while (idx < n_exp && k < 500) begin
            if (rd_pend) begin
                n_checks++; if (rd_data !== rd_exp) begin n_fail++; $display("FAIL rd_old_on_write got %h exp %h", rd_data, rd_exp); end
                rd_pend = 0;
            end
            s_tvalid = $urandom_range(0, 2) != 0;
            s_tdata  = dat[idx];
            s_tlast  = (idx == tlast_idx);
            rd_addr  = 4'(idx);
            if (s_tvalid && s_tready) begin
                if (mr_known[idx]) begin rd_pend = 1; rd_exp = mr[idx]; end
                mr[idx] = dat[idx];
                mr_known[idx] = 1;
                idx++;
            end
            tick();
            k++;
        end
        s_tvalid = 1'b1; s_tdata = 32'hdead_beef; s_tlast = 1'b1;
        if (rd_pend) begin
            n_checks++; if (rd_data !== rd_exp) begin n_fail++; $display("FAIL rd_old_on_write got %h exp %h", rd_data, rd_exp); end
        end
        n_checks++; if (idx != n_exp) begin n_fail++; $display("FAIL recv_timeout got %0d beats exp %0d", idx, n_exp); end
        n_checks++;
        if (done !== 1'b1 || err_tlast !== err_exp || s_tready !== 1'b0 || sel !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL recv_end got done=%b err=%b s_tready=%b sel=%b rdy=%b exp 1/%b/0/0/1", done, err_tlast, s_tready, sel, cmd_ready, err_exp);
        end
        tick();
        tick();
        s_tvalid = 1'b0; s_tlast = 1'b0;
        n_checks++; if (done !== 1'b1 || cmd_ready !== 1'b1 || m_tvalid !== 1'b0) begin n_fail++; $display("FAIL idle_after_run got done=%b rdy=%b vld=%b exp 1/1/0", done, cmd_ready, m_tvalid); end
    endtask

    task automatic check_results();
        for (int i = 0; i < SIZE; i++) begin
            if (mr_known[i]) begin
                rd_addr = 4'(i);
                tick();
                n_checks++; if (rd_data !== mr[i]) begin n_fail++; $display("FAIL result[%0d] got %h exp %h", i, rd_data, mr[i]); end
            end
        end
    endtask

    task automatic test_stream_basic();
        load_operands(1'b1);
        send_operands(0, -1, 1'b0, 1'b0);
        feed_results(SIZE - 1, 100);
        check_results();
    endtask

    task automatic test_stream_stall();
        send_operands(1, -1, 1'b0, 1'b0);
        feed_results(SIZE - 1, -1);
        load_operands(1'b0);
        send_operands(2, -1, 1'b1, 1'b1);
        feed_results(SIZE - 1, -1);
        check_results();
    endtask

    task automatic test_tlast_errors();
        send_operands(2, -1, 1'b0, 1'b0);
        feed_results(9, 200);
        check_results();
        send_operands(0, -1, 1'b1, 1'b0);
        feed_results(-1, -1);
        check_results();
    endtask

    task automatic test_reset_mid_run();
        load_operands(1'b0);
        send_operands(0, SIZE + 7, 1'b0, 1'b0);
        send_operands(0, -1, 1'b1, 1'b0);
        feed_results(SIZE - 1, -1);
        check_results();
    endtask

    initial begin
        rst = 1'b1; cmd_go = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr = '0; m_tready = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
        for (int i = 0; i < SIZE; i++) begin mr[i] = '0; mr_known[i] = 0; end
        test_reset();
        test_stream_basic();
        test_stream_stall();
        test_tlast_errors();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

endmodule
